// File: rtl/core_pkg.sv
// Shared core definitions: default datapath widths and writeback source encodings.
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;
    localparam int unsigned CORE_AW   = 5;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between the ALU (EX) and load (MEM) writeback paths.
// Loads win by default; a starvation counter forces an ALU win unless same-rd ordering applies.
module regfile_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = CORE_XLEN,
    parameter int unsigned AW         = CORE_AW,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            wEn,
    output logic [AW-1:0]   write_sel,
    output logic [XLEN-1:0] write_data,
    output logic [1:0]      grant_src,
    output logic            alu_starved
);

    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            saturated, same_rd;
    logic            alu_win, mem_win, any_win;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [1:0]      grant_src_d;

    always_comb begin
        saturated = (starve_cnt_q == STARVE_LIMIT);
        // The load is older; on a same-rd clash it must land first even when the ALU is owed.
        same_rd   = (alu_rd == mem_rd) && (alu_rd != '0);
        alu_win   = !reset && alu_valid && (!mem_valid || (saturated && !same_rd));
        mem_win   = !reset && mem_valid && !alu_win;
        any_win   = alu_win || mem_win;

        grant_rd    = mem_rd;
        grant_data  = mem_data;
        grant_src_d = SRC_NONE;
        if (alu_win) begin
            grant_rd    = alu_rd;
            grant_data  = alu_data;
            grant_src_d = SRC_ALU;
        end else if (mem_win) begin
            grant_src_d = SRC_MEM;
        end

        starve_cnt_d = starve_cnt_q;
        if (alu_win) begin
            starve_cnt_d = '0;
        end else if (mem_win && alu_valid && !saturated) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    assign alu_ready   = alu_win;
    assign mem_ready   = mem_win;
    assign alu_starved = saturated;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            wEn          <= 1'b0;
            write_sel    <= '0;
            write_data   <= '0;
            grant_src    <= SRC_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wEn          <= any_win && (grant_rd != '0);
            grant_src    <= grant_src_d;
            if (any_win) begin
                write_sel  <= grant_rd;
                write_data <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a behavioural model
// of the grant rules, starvation counter and the resulting register file contents.
module tb_regfile_wb_arbiter;
    import core_pkg::*;

    localparam int unsigned SMAX = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        wEn;
    logic [4:0]  write_sel;
    logic [31:0] write_data;
    logic [1:0]  grant_src;
    logic        alu_starved;

    regfile_wb_arbiter #(
        .XLEN       (32),
        .AW         (5),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .wEn         (wEn),
        .write_sel   (write_sel),
        .write_data  (write_data),
        .grant_src   (grant_src),
        .alu_starved (alu_starved)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference state: losses since the ALU last won, expected write port, expected regfile.
    int          m_losses;
    logic        m_wen;
    logic [4:0]  m_sel;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic [31:0] rf_model [32];
    logic [31:0] rf_dut   [32];
    logic        e_alu, e_mem;

    // Regfile sink fed by the DUT write port.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_dut[i] <= 32'd0;
        end else if (wEn) begin
            rf_dut[write_sel] <= write_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
    endtask

    // One clock cycle: check the handshake mid-cycle, then the registered port after the edge.
    task automatic step();
        bool_owed_check();
        @(posedge clock);
        #1;
        if (reset) begin
            m_losses = 0;
            m_wen    = 1'b0;
            m_sel    = 5'd0;
            m_data   = 32'd0;
            m_src    = SRC_NONE;
            for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        end else begin
            if (e_alu) m_losses = 0;
            else if (e_mem && alu_valid && m_losses < SMAX) m_losses++;
            m_wen = 1'b0;
            m_src = SRC_NONE;
            if (e_alu) begin
                m_wen = (alu_rd != 5'd0); m_sel = alu_rd; m_data = alu_data; m_src = SRC_ALU;
            end else if (e_mem) begin
                m_wen = (mem_rd != 5'd0); m_sel = mem_rd; m_data = mem_data; m_src = SRC_MEM;
            end
            if (m_wen) rf_model[m_sel] = m_data;
        end
        check("wEn", 64'(wEn), 64'(m_wen));
        check("write_sel", 64'(write_sel), 64'(m_sel));
        check("write_data", 64'(write_data), 64'(m_data));
        check("grant_src", 64'(grant_src), 64'(m_src));
    endtask

    task automatic bool_owed_check();
        bit owed, clash;
        #2;
        owed  = (m_losses == SMAX);
        clash = (alu_rd == mem_rd) && (alu_rd != 5'd0);
        if (reset) begin
            e_alu = 1'b0;
            e_mem = 1'b0;
        end else begin
            e_alu = alu_valid && (!mem_valid || (owed && !clash));
            e_mem = mem_valid && !e_alu;
        end
        check("alu_ready", 64'(alu_ready), 64'(e_alu));
        check("mem_ready", 64'(mem_ready), 64'(e_mem));
        check("alu_starved", 64'(alu_starved), 64'(owed));
    endtask

    initial begin
        bit          pa, pm;
        logic [4:0]  ra, rm;
        logic [31:0] da, dm;

        m_losses = 0;
        reset    = 1'b1;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        @(posedge clock);
        #1;

        // Reset held with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_wen", 64'(wEn), 64'd0);
            check("reset_sel", 64'(write_sel), 64'd0);
        end
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();

        // Single ALU request.
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        step();
        check("single_alu_ready", 64'(e_alu), 64'd1);
        check("single_wen", 64'(wEn), 64'd1);
        check("single_sel", 64'(write_sel), 64'd5);
        check("single_data", 64'(write_data), 64'h1234);
        check("single_src", 64'(grant_src), 64'(SRC_ALU));
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();

        // Continuous contention: ALU wins every fourth cycle.
        drive(1'b1, 5'd3, 32'hA1, 1'b1, 5'd4, 32'hB2);
        for (int i = 0; i < 8; i++) begin
            step();
            check("starve_pattern", 64'(grant_src), (i % 4 == 3) ? 64'(SRC_ALU) : 64'(SRC_MEM));
        end

        // Same-rd ordering with the counter saturated.
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd7, 32'hAAAA);
        step();
        check("order_first_src", 64'(grant_src), 64'(SRC_MEM));
        check("order_first_data", 64'(write_data), 64'hAAAA);
        mem_valid = 1'b0;
        step();
        check("order_second_data", 64'(write_data), 64'hBBBB);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        check("order_x7", 64'(rf_dut[7]), 64'hBBBB);

        // Load to x0.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        step();
        check("x0_ready", 64'(e_mem), 64'd1);
        check("x0_wen", 64'(wEn), 64'd0);
        check("x0_src", 64'(grant_src), 64'(SRC_MEM));
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();

        // Reset in the cycle after a grant, with the counter saturated.
        drive(1'b1, 5'd3, 32'hC3, 1'b1, 5'd4, 32'hD4);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        check("midreset_wen", 64'(wEn), 64'd0);
        check("midreset_starved", 64'(alu_starved), 64'd0);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();

        // Randomized traffic; each requester holds its transaction until granted.
        pa = 1'b0;
        pm = 1'b0;
        ra = 5'd0; rm = 5'd0; da = 32'd0; dm = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1'b1;
                ra = 5'($urandom_range(0, 7));
                da = $urandom;
            end
            if (!pm && ($urandom_range(0, 2) != 0)) begin
                pm = 1'b1;
                rm = 5'($urandom_range(0, 7));
                dm = $urandom;
            end
            drive(pa, ra, da, pm, rm, dm);
            step();
            if (e_alu) pa = 1'b0;
            if (e_mem) pm = 1'b0;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        for (int r = 0; r < 8; r++) begin
            check("random_rf", 64'(rf_dut[r]), 64'(rf_model[r]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
